lif_neuron_array: RTL and testbench

Time-multiplexed array of `N_NEURONS` leaky integrate-and-fire neurons that share one fixed-point update datapath. Each neuron can also have spike-frequency adaptation: its firing threshold rises on every spike and decays between spikes. Per-neuron currents stream in through a valid/ready interface in round-robin neuron order. Each neuron update produces one registered output beat carrying the index, membrane value and spike flag. The block is the scale-up of the single `lif_neuron` for multi-neuron layers, and is fed from `poisson_spike_gen`-driven current summers.

---
 rtl/lif_neuron_array_pkg.sv | 42 ++++
 rtl/lif_neuron_array_update_core.sv | 78 +++++++
 rtl/lif_neuron_array.sv | 129 ++++++++++++
 tb/tb_lif_neuron_array.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lif_neuron_array_pkg.sv
// Shared fixed-point types, constants and helpers for the LIF neuron array.
// All membrane, threshold and current values are signed Q(LIF_W-LIF_Q).LIF_Q.
package lif_neuron_array_pkg;

    localparam int LIF_W = 16;
    localparam int LIF_Q = 12;

    typedef logic signed [LIF_W-1:0] fx_t;
    typedef logic signed [LIF_W+1:0] fx_wide_t;

    localparam int FX_MAX_I = (1 << (LIF_W - 1)) - 1;
    localparam int FX_MIN_I = -(1 << (LIF_W - 1));
    localparam fx_t FX_MAX  = fx_t'(FX_MAX_I);
    localparam fx_t FX_MIN  = fx_t'(FX_MIN_I);

    // Common fixed-point constants (round(x * 2^LIF_Q)).
    localparam int FX_0_0  = 0;
    localparam int FX_1_0  = 1 << LIF_Q;
    localparam int FX_0_96 = 3932;

    typedef struct packed {
        fx_t  vmem;
        logic spike;
        logic last;
    } lif_beat_t;

    // Clamp a widened intermediate back into the fx_t range.
    function automatic fx_t sat_fx(input fx_wide_t x);
        if (x > fx_wide_t'(FX_MAX)) begin
            return FX_MAX;
        end
        if (x < fx_wide_t'(FX_MIN)) begin
            return FX_MIN;
        end
        return fx_t'(x);
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lif_neuron_array_update_core.sv
// Combinational single-neuron LIF update: leak, integrate, saturate, threshold
// compare, refractory countdown and threshold adaptation.
module lif_update_core
    import lif_neuron_array_pkg::*;
#(
    parameter int RW          = 2,
    parameter int V_TH        = FX_1_0,
    parameter int V_RESET     = FX_0_0,
    parameter int V_REST      = FX_0_0,
    parameter int LEAK_A      = FX_0_96,
    parameter int REFR_TICKS  = 3,
    parameter int TH_INC      = FX_0_0,
    parameter int TH_DECAY_SH = 4
) (
    input  logic signed [LIF_W-1:0] i_vmem,
    input  logic [RW-1:0]           i_refr,
    input  logic signed [LIF_W-1:0] i_th_ad,
    input  logic signed [LIF_W-1:0] i_cur,
    output logic signed [LIF_W-1:0] o_vmem,
    output logic [RW-1:0]           o_refr,
    output logic signed [LIF_W-1:0] o_th_ad,
    output logic                    o_spike
);

    localparam int  W          = LIF_W;
    localparam fx_t V_TH_FX    = fx_t'(V_TH);
    localparam fx_t V_RESET_FX = fx_t'(V_RESET);
    localparam fx_t V_REST_FX  = fx_t'(V_REST);
    localparam fx_t LEAK_A_FX  = fx_t'(LEAK_A);

    logic signed [W:0]   w_diff;
    logic signed [2*W:0] w_mult;
    fx_wide_t            w_leak;
    fx_wide_t            w_sum;
    fx_t                 w_v;
    fx_t                 w_th_eff;
    fx_t                 w_th_dec;
    logic [W:0]          w_th_inc;
    logic                w_refractory;
    logic                w_fire;

    // Leak is applied to the distance from rest, so the product is kept at full width.
    assign w_diff   = (W+1)'(i_vmem) - (W+1)'(V_REST_FX);
    assign w_mult   = (2*W+1)'(LEAK_A_FX) * (2*W+1)'(w_diff);
    assign w_leak   = fx_wide_t'(w_mult >>> LIF_Q);
    assign w_sum    = fx_wide_t'(V_REST_FX) + w_leak + fx_wide_t'(i_cur);
    assign w_v      = sat_fx(w_sum);
    assign w_th_eff = sat_fx(fx_wide_t'(V_TH_FX) + fx_wide_t'(i_th_ad));

    assign w_refractory = (i_refr != '0);
    assign w_fire       = !w_refractory && (w_v >= w_th_eff);

    // th_ad is never negative, so the decay and increment can run unsigned.
    assign w_th_dec = i_th_ad - (i_th_ad >>> TH_DECAY_SH);
    assign w_th_inc = {1'b0, w_th_dec} + (W+1)'(TH_INC);

    always_comb begin
        o_spike = w_fire;
        o_vmem  = (w_refractory || w_fire) ? V_RESET_FX : w_v;

        if (w_refractory) begin
            o_refr = i_refr - RW'(1);
        end else if (w_fire) begin
            o_refr = RW'(REFR_TICKS);
        end else begin
            o_refr = '0;
        end

        if (!w_fire) begin
            o_th_ad = w_th_dec;
        end else if (w_th_inc > (W+1)'(FX_MAX_I)) begin
            o_th_ad = FX_MAX;
        end else begin
            o_th_ad = fx_t'(w_th_inc);
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of LIF neurons sharing one update datapath; currents
// arrive round-robin by neuron index and each update emits one output beat.
module lif_neuron_array
    import lif_neuron_array_pkg::*;
#(
    parameter int N_NEURONS   = 8,
    parameter int V_TH        = FX_1_0,
    parameter int V_RESET     = FX_0_0,
    parameter int V_REST      = FX_0_0,
    parameter int LEAK_A      = FX_0_96,
    parameter int REFR_TICKS  = 3,
    parameter int TH_INC      = FX_0_0,
    parameter int TH_DECAY_SH = 4,
    localparam int IDX_W      = idx_w(N_NEURONS),
    localparam int RW         = idx_w(REFR_TICKS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [LIF_W-1:0] in_cur,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_idx,
    output logic signed [LIF_W-1:0] out_vmem,
    output logic                    out_spike,
    output logic                    out_last
);

    localparam fx_t V_RESET_FX = fx_t'(V_RESET);

    logic [IDX_W-1:0]        r_ptr;
    logic signed [LIF_W-1:0] r_vmem  [N_NEURONS];
    logic [RW-1:0]           r_refr  [N_NEURONS];
    logic signed [LIF_W-1:0] r_th_ad [N_NEURONS];

    logic                    r_out_valid;
    logic [IDX_W-1:0]        r_out_idx;
    lif_beat_t               r_out;

    logic                    w_accept;
    logic                    w_ptr_last;
    logic signed [LIF_W-1:0] w_nxt_vmem;
    logic [RW-1:0]           w_nxt_refr;
    logic signed [LIF_W-1:0] w_nxt_th_ad;
    logic                    w_nxt_spike;

    assign in_ready   = !clr && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_ptr_last = (r_ptr == IDX_W'(N_NEURONS - 1));

    // State is read straight from the arrays so a single neuron can update every cycle.
    lif_update_core #(
        .RW          (RW),
        .V_TH        (V_TH),
        .V_RESET     (V_RESET),
        .V_REST      (V_REST),
        .LEAK_A      (LEAK_A),
        .REFR_TICKS  (REFR_TICKS),
        .TH_INC      (TH_INC),
        .TH_DECAY_SH (TH_DECAY_SH)
    ) u_core (
        .i_vmem  (r_vmem[r_ptr]),
        .i_refr  (r_refr[r_ptr]),
        .i_th_ad (r_th_ad[r_ptr]),
        .i_cur   (in_cur),
        .o_vmem  (w_nxt_vmem),
        .o_refr  (w_nxt_refr),
        .o_th_ad (w_nxt_th_ad),
        .o_spike (w_nxt_spike)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                r_vmem[n]  <= V_RESET_FX;
                r_refr[n]  <= '0;
                r_th_ad[n] <= '0;
            end
        end else if (clr) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                r_vmem[n]  <= V_RESET_FX;
                r_refr[n]  <= '0;
                r_th_ad[n] <= '0;
            end
        end else if (w_accept) begin
            r_vmem[r_ptr]  <= w_nxt_vmem;
            r_refr[r_ptr]  <= w_nxt_refr;
            r_th_ad[r_ptr] <= w_nxt_th_ad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_last ? '0 : r_ptr + IDX_W'(1);
        end
    end

    // Output register holds its beat while stalled; it drops valid only once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out       <= '{vmem: V_RESET_FX, spike: 1'b0, last: 1'b0};
        end else if (clr) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_out       <= '{vmem: V_RESET_FX, spike: 1'b0, last: 1'b0};
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_idx   <= r_ptr;
            r_out       <= '{vmem: w_nxt_vmem, spike: w_nxt_spike, last: w_ptr_last};
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_vmem  = r_out.vmem;
    assign out_spike = r_out.spike;
    assign out_last  = r_out.last;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Bench for lif_neuron_array: four configurations share one input stream and
// are checked against a behavioural per-neuron model of the LIF update rules.
module tb_lif_neuron_array;
    import lif_neuron_array_pkg::*;

    localparam int ND = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               clr;
    logic               in_valid;
    logic               out_ready;
    logic signed [15:0] in_cur;

    logic               w_rdy [ND];
    logic               w_val [ND];
    logic               w_spk [ND];
    logic               w_lst [ND];
    logic signed [15:0] w_vm  [ND];
    logic [1:0]         w_ix  [ND];
    logic [1:0]         ix0;
    logic [0:0]         ix1, ix2, ix3;

    assign w_ix[0] = ix0;
    assign w_ix[1] = {1'b0, ix1};
    assign w_ix[2] = {1'b0, ix2};
    assign w_ix[3] = {1'b0, ix3};

    // dut0: default 4-neuron array; dut1: adaptation; dut2: saturating threshold; dut3: single neuron.
    lif_neuron_array #(.N_NEURONS(4)) u_main (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(w_rdy[0]),
        .in_cur(in_cur), .out_valid(w_val[0]), .out_ready(out_ready), .out_idx(ix0),
        .out_vmem(w_vm[0]), .out_spike(w_spk[0]), .out_last(w_lst[0]));

    lif_neuron_array #(.N_NEURONS(1), .REFR_TICKS(0), .TH_INC(2048)) u_adp (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(w_rdy[1]),
        .in_cur(in_cur), .out_valid(w_val[1]), .out_ready(out_ready), .out_idx(ix1),
        .out_vmem(w_vm[1]), .out_spike(w_spk[1]), .out_last(w_lst[1]));

    lif_neuron_array #(.N_NEURONS(1), .V_TH(32767)) u_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(w_rdy[2]),
        .in_cur(in_cur), .out_valid(w_val[2]), .out_ready(out_ready), .out_idx(ix2),
        .out_vmem(w_vm[2]), .out_spike(w_spk[2]), .out_last(w_lst[2]));

    lif_neuron_array #(.N_NEURONS(1)) u_one (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(w_rdy[3]),
        .in_cur(in_cur), .out_valid(w_val[3]), .out_ready(out_ready), .out_idx(ix3),
        .out_vmem(w_vm[3]), .out_spike(w_spk[3]), .out_last(w_lst[3]));

    int nn     [ND] = '{4, 1, 1, 1};
    int c_vth  [ND] = '{4096, 4096, 32767, 4096};
    int c_refr [ND] = '{3, 0, 3, 3};
    int c_inc  [ND] = '{0, 2048, 0, 0};

    int m_vm [ND][4];
    int m_rf [ND][4];
    int m_th [ND][4];
    int m_ptr[ND];
    int e_vm [ND];
    int e_sp [ND];
    int e_ix [ND];
    int e_ls [ND];
    bit e_valid;

    int tests_run = 0;
    int failures  = 0;

    function automatic int sat(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < ND; d++) begin
            for (int n = 0; n < 4; n++) begin
                m_vm[d][n] = 0;
                m_rf[d][n] = 0;
                m_th[d][n] = 0;
            end
            m_ptr[d] = 0;
        end
    endtask

    task automatic model_accept(input int cur);
        int p, v, th_eff, spk;
        for (int d = 0; d < ND; d++) begin
            p   = m_ptr[d];
            spk = 0;
            if (m_rf[d][p] > 0) begin
                m_rf[d][p] = m_rf[d][p] - 1;
                m_vm[d][p] = 0;
            end else begin
                v      = sat(((3932 * m_vm[d][p]) >>> 12) + cur);
                th_eff = sat(c_vth[d] + m_th[d][p]);
                if (v >= th_eff) begin
                    spk        = 1;
                    m_vm[d][p] = 0;
                    m_rf[d][p] = c_refr[d];
                end else begin
                    m_vm[d][p] = v;
                end
            end
            m_th[d][p] = m_th[d][p] - (m_th[d][p] >>> 4);
            if (spk == 1) m_th[d][p] = (m_th[d][p] + c_inc[d] > 32767) ? 32767 : m_th[d][p] + c_inc[d];
            e_vm[d]  = m_vm[d][p];
            e_sp[d]  = spk;
            e_ix[d]  = p;
            e_ls[d]  = (p == nn[d] - 1) ? 1 : 0;
            m_ptr[d] = (p + 1) % nn[d];
        end
    endtask

    // Drives one cycle at the falling edge and returns what the DUT did at the next rising edge.
    task automatic step(input bit v, input int cur, input bit ordy, input bit c,
                        output bit acc, output bit rdy);
        @(negedge clk);
        in_valid  = v;
        in_cur    = 16'(cur);
        out_ready = ordy;
        clr       = c;
        #1;
        rdy = w_rdy[0];
        acc = v && w_rdy[0];
        @(posedge clk);
        #1;
        if (c) model_clear();
        else if (acc) model_accept(cur);
        if (c) e_valid = 1'b0;
        else if (acc) e_valid = 1'b1;
        else if (ordy) e_valid = 1'b0;
        if (acc) $display("[TB] beat idx=%0d cur=%0d vmem=%0d spike=%0b", w_ix[0], cur, w_vm[0], w_spk[0]);
        in_valid = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < ND; d++) begin
            tests_run++;
            if ({w_rdy[d], w_val[d], w_ix[d], w_vm[d], w_spk[d], w_lst[d]} !== {1'b1, 1'b0, 2'd0, 16'sd0, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL reset_state dut%0d got rdy=%b valid=%b idx=%0d vmem=%0d spk=%b last=%b want 1 0 0 0 0 0",
                         d, w_rdy[d], w_val[d], w_ix[d], w_vm[d], w_spk[d], w_lst[d]);
            end
        end
    endtask

    task automatic test_firing();
        int n0_vm[8] = '{2048, 4014, 0, 0, 0, 0, 2048, 4014};
        int n0_sp[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        bit acc, rdy;
        step(1'b0, 0, 1'b1, 1'b1, acc, rdy);
        for (int t = 0; t < 8; t++) begin
            for (int n = 0; n < 4; n++) begin
                step(1'b1, (n == 0) ? 2048 : 0, 1'b1, 1'b0, acc, rdy);
                tests_run++;
                if (!acc) begin
                    failures++;
                    $display("FAIL firing_accept tick=%0d n=%0d got ready=%b want 1", t, n, rdy);
                end
                for (int d = 0; d < ND; d++) begin
                    tests_run++;
                    if ({w_val[d], w_ix[d], w_vm[d], w_spk[d], w_lst[d]} !==
                        {1'b1, 2'(e_ix[d]), 16'(e_vm[d]), 1'(e_sp[d]), 1'(e_ls[d])}) begin
                        failures++;
                        $display("FAIL firing_beat dut%0d got v=%b idx=%0d vmem=%0d spk=%b last=%b want v=1 idx=%0d vmem=%0d spk=%0d last=%0d",
                                 d, w_val[d], w_ix[d], w_vm[d], w_spk[d], w_lst[d], e_ix[d], e_vm[d], e_sp[d], e_ls[d]);
                    end
                end
                tests_run++;
                if (n == 0 && (w_vm[0] !== 16'(n0_vm[t]) || w_spk[0] !== 1'(n0_sp[t]))) begin
                    failures++;
                    $display("FAIL firing_n0 tick=%0d got vmem=%0d spk=%b want vmem=%0d spk=%0d", t, w_vm[0], w_spk[0], n0_vm[t], n0_sp[t]);
                end else if (n != 0 && (w_vm[0] !== 16'sd0 || w_spk[0] !== 1'b0)) begin
                    failures++;
                    $display("FAIL firing_quiet tick=%0d n=%0d got vmem=%0d spk=%b want 0 0", t, n, w_vm[0], w_spk[0]);
                end
            end
        end
    endtask

    task automatic test_adaptation();
        int sp_at[$];
        bit acc, rdy;
        step(1'b0, 0, 1'b1, 1'b1, acc, rdy);
        for (int u = 0; u < 30; u++) begin
            step(1'b1, 2458, 1'b1, 1'b0, acc, rdy);
            tests_run++;
            if ({acc, w_vm[1], w_spk[1]} !== {1'b1, 16'(e_vm[1]), 1'(e_sp[1])}) begin
                failures++;
                $display("FAIL adapt_beat u=%0d got acc=%b vmem=%0d spk=%b want acc=1 vmem=%0d spk=%0d", u, acc, w_vm[1], w_spk[1], e_vm[1], e_sp[1]);
            end
            if (w_spk[1] === 1'b1) sp_at.push_back(u);
        end
        tests_run++;
        if (sp_at.size() < 2 || sp_at[0] != 1 || sp_at[1] - sp_at[0] < 3) begin
            failures++;
            $display("FAIL adapt_isi got spikes=%0d first=%0d second=%0d want first=1 gap>=3", sp_at.size(),
                     (sp_at.size() > 0) ? sp_at[0] : -1, (sp_at.size() > 1) ? sp_at[1] : -1);
        end
    endtask

    task automatic test_saturation();
        bit acc, rdy;
        step(1'b0, 0, 1'b1, 1'b1, acc, rdy);
        for (int u = 0; u < 16; u++) begin
            step(1'b1, (u < 8) ? 32767 : -32768, 1'b1, 1'b0, acc, rdy);
            for (int d = 0; d < ND; d++) begin
                tests_run++;
                if ({w_ix[d], w_vm[d], w_spk[d], w_lst[d]} !== {2'(e_ix[d]), 16'(e_vm[d]), 1'(e_sp[d]), 1'(e_ls[d])}) begin
                    failures++;
                    $display("FAIL sat_beat dut%0d u=%0d got idx=%0d vmem=%0d spk=%b want idx=%0d vmem=%0d spk=%0d",
                             d, u, w_ix[d], w_vm[d], w_spk[d], e_ix[d], e_vm[d], e_sp[d]);
                end
            end
            tests_run++;
            if (u < 8 && (w_vm[2] < 0 || w_spk[2] !== ((u % 4 == 0) ? 1'b1 : 1'b0))) begin
                failures++;
                $display("FAIL sat_max u=%0d got vmem=%0d spk=%b want vmem>=0 spk=%0d", u, w_vm[2], w_spk[2], (u % 4 == 0));
            end else if (u >= 8 && w_vm[2] !== -16'sd32768) begin
                failures++;
                $display("FAIL sat_min u=%0d got vmem=%0d want -32768", u, w_vm[2]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit acc, rdy, v, ordy, stall, exp_rdy;
        int cur;
        logic [20:0] snap;
        step(1'b0, 0, 1'b1, 1'b1, acc, rdy);
        for (int c = 0; c < 300; c++) begin
            v       = ($urandom_range(0, 99) < 70);
            ordy    = $urandom_range(0, 1) == 1;
            cur     = int'($urandom_range(0, 9000)) - 3000;
            exp_rdy = !e_valid || ordy;
            stall   = e_valid && !ordy;
            snap    = {w_ix[0], w_vm[0], w_spk[0], w_lst[0], w_val[0]};
            step(v, cur, ordy, 1'b0, acc, rdy);
            tests_run++;
            if (rdy !== exp_rdy || w_val[0] !== e_valid) begin
                failures++;
                $display("FAIL bp_handshake cyc=%0d got ready=%b valid=%b want ready=%b valid=%b", c, rdy, w_val[0], exp_rdy, e_valid);
            end
            if (acc) begin
                for (int d = 0; d < ND; d++) begin
                    tests_run++;
                    if ({w_rdy[d], w_ix[d], w_vm[d], w_spk[d], w_lst[d]} !==
                        {w_rdy[0], 2'(e_ix[d]), 16'(e_vm[d]), 1'(e_sp[d]), 1'(e_ls[d])}) begin
                        failures++;
                        $display("FAIL bp_beat dut%0d cyc=%0d got idx=%0d vmem=%0d spk=%b last=%b want idx=%0d vmem=%0d spk=%0d last=%0d",
                                 d, c, w_ix[d], w_vm[d], w_spk[d], w_lst[d], e_ix[d], e_vm[d], e_sp[d], e_ls[d]);
                    end
                end
            end else if (stall) begin
                tests_run++;
                if ({w_ix[0], w_vm[0], w_spk[0], w_lst[0], w_val[0]} !== snap) begin
                    failures++;
                    $display("FAIL bp_hold cyc=%0d got vmem=%0d idx=%0d want vmem=%0d idx=%0d held",
                             c, w_vm[0], w_ix[0], $signed(snap[18:3]), snap[20:19]);
                end
            end
        end
    endtask

    task automatic test_clear();
        bit acc, rdy;
        step(1'b0, 0, 1'b1, 1'b1, acc, rdy);
        step(1'b1, 500, 1'b1, 1'b0, acc, rdy);
        step(1'b1, 500, 1'b1, 1'b0, acc, rdy);
        step(1'b1, 777, 1'b1, 1'b1, acc, rdy);
        tests_run++;
        if (acc || rdy || w_val[0] !== 1'b0) begin
            failures++;
            $display("FAIL clr_block got acc=%b ready=%b valid=%b want 0 0 0", acc, rdy, w_val[0]);
        end
        step(1'b1, 1000, 1'b1, 1'b0, acc, rdy);
        tests_run++;
        if ({acc, w_ix[0], w_vm[0], w_spk[0]} !== {1'b1, 2'd0, 16'sd1000, 1'b0}) begin
            failures++;
            $display("FAIL clr_restart got acc=%b idx=%0d vmem=%0d spk=%b want 1 0 1000 0", acc, w_ix[0], w_vm[0], w_spk[0]);
        end
        step(1'b0, 0, 1'b0, 1'b0, acc, rdy);
        tests_run++;
        if (w_val[0] !== 1'b1 || w_vm[0] !== 16'sd1000) begin
            failures++;
            $display("FAIL rst_stall got valid=%b vmem=%0d want 1 1000", w_val[0], w_vm[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            tests_run++;
            if ({w_val[d], w_vm[d], w_ix[d]} !== {1'b0, 16'sd0, 2'd0}) begin
                failures++;
                $display("FAIL rst_async dut%0d got valid=%b vmem=%0d idx=%0d want 0 0 0", d, w_val[d], w_vm[d], w_ix[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        e_valid = 1'b0;
        step(1'b1, 300, 1'b1, 1'b0, acc, rdy);
        tests_run++;
        if ({acc, w_ix[0], w_vm[0], w_ix[1], w_vm[1]} !== {1'b1, 2'd0, 16'sd300, 2'd0, 16'sd300}) begin
            failures++;
            $display("FAIL rst_restart got acc=%b idx=%0d vmem=%0d idx1=%0d vmem1=%0d want 1 0 300 0 300",
                     acc, w_ix[0], w_vm[0], w_ix[1], w_vm[1]);
        end
    endtask

    task automatic test_back_to_back();
        int seq_vm[6] = '{2048, 4014, 0, 0, 0, 0};
        bit acc, rdy;
        step(1'b0, 0, 1'b1, 1'b1, acc, rdy);
        for (int u = 0; u < 20; u++) begin
            step(1'b1, 2048, 1'b1, 1'b0, acc, rdy);
            tests_run++;
            if ({rdy, w_val[3], w_vm[3], w_spk[3], w_lst[3]} !==
                {1'b1, 1'b1, 16'(seq_vm[u % 6]), (u % 6 == 2) ? 1'b1 : 1'b0, 1'b1} ||
                w_vm[3] !== 16'(e_vm[3]) || w_spk[3] !== 1'(e_sp[3])) begin
                failures++;
                $display("FAIL b2b u=%0d got ready=%b vmem=%0d spk=%b last=%b want ready=1 vmem=%0d spk=%0d last=1",
                         u, rdy, w_vm[3], w_spk[3], w_lst[3], seq_vm[u % 6], (u % 6 == 2));
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_cur    = '0;
        e_valid   = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_reset();
        test_firing();
        test_adaptation();
        test_saturation();
        test_backpressure();
        test_clear();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
